// File: rtl/iigs_sd_pkg.sv
// Shared types and constants for the IIgs virtual-disk request scheduler.
package iigs_sd_pkg;

  // Scheduler FSM: wait for work, wait for the HPS ack rise, wait for the ack fall.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } sd_state_t;

  localparam int SD_NDEV  = 2;
  localparam int SD_LBA_W = 32;

endpackage

// File: rtl/sd_rr_pick.sv
// Combinational round-robin picker: first pending device after the last grant.
module sd_rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pend_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan N candidates starting just after the last grant; the last one scanned
  // is the last grant itself, so a lone requester can be re-served.
  always_comb begin
    found = 1'b0;
    idx_o = last_i;
    cand  = last_i;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_i) + k) % N);
      if (!found && pend_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/sd_req_scheduler.sv
// Sector-transfer scheduler between the IIgs disk controllers and the HPS
// virtual-disk handshake. Latches per-device requests, serves them one at a
// time round-robin, holds the CPU in wait while a transfer runs, and aborts
// stalled handshakes with a saturating watchdog.
module sd_req_scheduler
  import iigs_sd_pkg::*;
#(
  parameter  int NDEV        = SD_NDEV,
  parameter  int TIMEOUT_CYC = 33554432,
  localparam int GW          = (NDEV > 1) ? $clog2(NDEV) : 1,
  localparam int WDW         = $clog2(TIMEOUT_CYC)
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [NDEV-1:0]          dev_rd,
  input  logic [NDEV-1:0]          dev_wr,
  input  logic [NDEV*SD_LBA_W-1:0] dev_lba,
  input  logic [NDEV-1:0]          img_mounted,
  input  logic [NDEV-1:0]          sd_ack,
  output logic [NDEV*SD_LBA_W-1:0] sd_lba,
  output logic [NDEV-1:0]          sd_rd,
  output logic [NDEV-1:0]          sd_wr,
  output logic                     cpu_wait,
  output logic [NDEV-1:0]          dev_busy,
  output logic [NDEV-1:0]          dev_done,
  output logic [NDEV-1:0]          dev_err,
  output logic [GW-1:0]            grant
);

  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
  localparam logic [WDW-1:0] WD_SAT  = {WDW{1'b1}};

  sd_state_t state_q, state_d;

  logic [NDEV-1:0]                pend_rd_q, pend_rd_d;
  logic [NDEV-1:0]                pend_wr_q, pend_wr_d;
  logic [NDEV-1:0][SD_LBA_W-1:0]  pend_lba_q, pend_lba_d;
  logic [NDEV-1:0][SD_LBA_W-1:0]  sd_lba_q, sd_lba_d;
  logic [NDEV-1:0]                sd_rd_q, sd_rd_d;
  logic [NDEV-1:0]                sd_wr_q, sd_wr_d;
  logic                           cpu_wait_q, cpu_wait_d;
  logic [NDEV-1:0]                done_q, done_d;
  logic [NDEV-1:0]                err_q, err_d;
  logic [GW-1:0]                  grant_q, grant_d;
  logic [WDW-1:0]                 wd_q, wd_d;
  logic [NDEV-1:0]                ack_q;
  logic                           srv_wr_q, srv_wr_d;

  logic                           pick_valid;
  logic [GW-1:0]                  pick_idx;
  logic                           ack_rise, ack_fall, wd_expired;
  logic [NDEV-1:0]                clr_rd, clr_wr;

  sd_rr_pick #(
    .N (NDEV)
  ) u_pick (
    .pend_i  (pend_rd_q | pend_wr_q),
    .last_i  (grant_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Next-state logic: FSM transitions, strobes, pulses, watchdog and pending bits.
  always_comb begin
    state_d    = state_q;
    pend_lba_d = pend_lba_q;
    sd_lba_d   = sd_lba_q;
    sd_rd_d    = sd_rd_q;
    sd_wr_d    = sd_wr_q;
    cpu_wait_d = cpu_wait_q;
    done_d     = '0;
    err_d      = '0;
    grant_d    = grant_q;
    srv_wr_d   = srv_wr_q;
    clr_rd     = '0;
    clr_wr     = '0;
    wd_d       = wd_q;

    // Only the granted device's ack matters; others are ignored.
    ack_rise   = sd_ack[grant_q] & ~ack_q[grant_q];
    ack_fall   = ~sd_ack[grant_q] & ack_q[grant_q];
    wd_expired = (wd_q == WD_LAST);

    // Watchdog runs in both handshake phases and sticks at its maximum.
    if (state_q != IDLE && wd_q != WD_SAT) begin
      wd_d = wd_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d            = pick_idx;
          sd_lba_d[pick_idx] = pend_lba_q[pick_idx];
          // Writes go first so a read-after-write sees the new data.
          if (pend_wr_q[pick_idx]) begin
            sd_wr_d[pick_idx] = 1'b1;
            srv_wr_d          = 1'b1;
          end else begin
            sd_rd_d[pick_idx] = 1'b1;
            srv_wr_d          = 1'b0;
          end
          cpu_wait_d = 1'b1;
          wd_d       = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (ack_rise) begin
          sd_rd_d          = '0;
          sd_wr_d          = '0;
          clr_wr[grant_q]  = srv_wr_q;
          clr_rd[grant_q]  = ~srv_wr_q;
          wd_d             = '0;
          state_d          = XFER;
        end else if (wd_expired) begin
          sd_rd_d          = '0;
          sd_wr_d          = '0;
          clr_wr[grant_q]  = srv_wr_q;
          clr_rd[grant_q]  = ~srv_wr_q;
          err_d[grant_q]   = 1'b1;
          cpu_wait_d       = 1'b0;
          wd_d             = '0;
          state_d          = IDLE;
        end
      end
      XFER: begin
        if (ack_fall) begin
          done_d[grant_q]  = 1'b1;
          cpu_wait_d       = 1'b0;
          state_d          = IDLE;
        end else if (wd_expired) begin
          err_d[grant_q]   = 1'b1;
          cpu_wait_d       = 1'b0;
          wd_d             = '0;
          state_d          = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh request always survives a clear in the same cycle.
    pend_rd_d = (pend_rd_q & ~clr_rd & ~img_mounted) | dev_rd;
    pend_wr_d = (pend_wr_q & ~clr_wr & ~img_mounted) | dev_wr;

    for (int d = 0; d < NDEV; d++) begin
      if (dev_rd[d] | dev_wr[d]) begin
        pend_lba_d[d] = dev_lba[d*SD_LBA_W +: SD_LBA_W];
      end
    end
  end

  // State register; grant resets to the last device so device 0 wins first.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      pend_lba_q <= '0;
      sd_lba_q   <= '0;
      sd_rd_q    <= '0;
      sd_wr_q    <= '0;
      cpu_wait_q <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      grant_q    <= GW'(NDEV - 1);
      wd_q       <= '0;
      ack_q      <= '0;
      srv_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      pend_lba_q <= pend_lba_d;
      sd_lba_q   <= sd_lba_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      cpu_wait_q <= cpu_wait_d;
      done_q     <= done_d;
      err_q      <= err_d;
      grant_q    <= grant_d;
      wd_q       <= wd_d;
      ack_q      <= sd_ack;
      srv_wr_q   <= srv_wr_d;
    end
  end

  // Busy covers both queued work and the device currently on the bus.
  genvar gi;
  generate
    for (gi = 0; gi < NDEV; gi++) begin : g_busy
      assign dev_busy[gi] = pend_rd_q[gi] | pend_wr_q[gi] |
                            ((state_q != IDLE) && (grant_q == GW'(gi)));
    end
  endgenerate

  assign sd_lba   = sd_lba_q;
  assign sd_rd    = sd_rd_q;
  assign sd_wr    = sd_wr_q;
  assign cpu_wait = cpu_wait_q;
  assign dev_done = done_q;
  assign dev_err  = err_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_sd_req_scheduler.sv
// Self-checking bench for sd_req_scheduler: scoreboard of expected transfers
// checked whenever the DUT completes or aborts one, plus direct timing checks.
module tb_sd_req_scheduler;

  localparam int TB_TO = 1024;

  typedef struct {
    int          dev;
    logic        wr;
    logic [31:0] lba;
    logic        err;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  dev_rd = '0;
  logic [1:0]  dev_wr = '0;
  logic [63:0] dev_lba = '0;
  logic [1:0]  img_mounted = '0;
  logic [1:0]  sd_ack = '0;
  logic [63:0] sd_lba;
  logic [1:0]  sd_rd, sd_wr, dev_busy, dev_done, dev_err;
  logic        cpu_wait;
  logic        grant;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t sb_q[$];

  // Monitor state
  logic [1:0]  prev_strb = '0;
  int          strb_cnt[2] = '{0, 0};
  int          done_cnt[2] = '{0, 0};
  int          err_cnt[2]  = '{0, 0};
  int          strb_run = 0;
  int          strb_len_last = 0;
  logic        act_wr = 1'b0;
  logic [31:0] act_lba = '0;
  logic        prev_cw = 1'b0;
  int          cw_run = 0;
  int          cw_high_last = 0;
  int          cw_low_last = 0;

  sd_req_scheduler #(
    .NDEV        (2),
    .TIMEOUT_CYC (TB_TO)
  ) u_dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .dev_rd      (dev_rd),
    .dev_wr      (dev_wr),
    .dev_lba     (dev_lba),
    .img_mounted (img_mounted),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .cpu_wait    (cpu_wait),
    .dev_busy    (dev_busy),
    .dev_done    (dev_done),
    .dev_err     (dev_err),
    .grant       (grant)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic sb_push(input int dev, input logic wr, input logic [31:0] lba, input logic err);
    exp_t e;
    e.dev = dev; e.wr = wr; e.lba = lba; e.err = err;
    sb_q.push_back(e);
  endtask

  // One-cycle request pulse; on return the pulse has been sampled.
  task automatic pulse_req(input logic [1:0] rd, input logic [1:0] wr,
                           input logic [31:0] lba0, input logic [31:0] lba1);
    dev_rd  = rd;
    dev_wr  = wr;
    dev_lba = {lba1, lba0};
    tick(1);
    dev_rd  = '0;
    dev_wr  = '0;
  endtask

  // HPS model: wait for the strobe, raise ack after rdly cycles, hold it for hold cycles.
  task automatic hps_serve(input int d, input int rdly, input int hold);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (sd_rd[d] | sd_wr[d]) seen = 1'b1;
      else tick(1);
    end
    chk($sformatf("strobe_seen_dev%0d", d), 64'(seen), 64'd1);
    if (seen) begin
      tick(rdly - 1);
      sd_ack[d] = 1'b1;
      tick(hold);
      sd_ack[d] = 1'b0;
      tick(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // Track strobes and cpu_wait runs; pop the scoreboard on every done/err pulse.
  always @(negedge clk_sys) begin
    for (int d = 0; d < 2; d++) begin
      logic strb;
      strb = sd_rd[d] | sd_wr[d];
      if (strb && !prev_strb[d]) begin
        strb_cnt[d]++;
        act_wr   = sd_wr[d];
        act_lba  = sd_lba[d*32 +: 32];
        strb_run = 0;
      end
      if (strb) strb_run++;
      if (!strb && prev_strb[d]) strb_len_last = strb_run;
      prev_strb[d] = strb;
      if (dev_done[d] === 1'b1 || dev_err[d] === 1'b1) begin
        exp_t e;
        if (dev_done[d] === 1'b1) done_cnt[d]++;
        if (dev_err[d] === 1'b1) err_cnt[d]++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_completion", 64'(d), 64'hFFFF);
        end else begin
          e = sb_q.pop_front();
          chk("sb_dev", 64'(d), 64'(e.dev));
          chk("sb_kind_wr", 64'(act_wr), 64'(e.wr));
          chk("sb_lba", 64'(act_lba), 64'(e.lba));
          chk("sb_err", 64'(dev_err[d]), 64'(e.err));
        end
      end
    end
    if (cpu_wait === prev_cw) begin
      cw_run++;
    end else begin
      if (prev_cw) cw_high_last = cw_run;
      else cw_low_last = cw_run;
      cw_run = 1;
    end
    prev_cw = cpu_wait;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, d1, e0, s1;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    chk("rst_grant", 64'(grant), 64'd1);
    chk("rst_sd_rd", 64'(sd_rd), 64'd0);
    chk("rst_sd_wr", 64'(sd_wr), 64'd0);
    chk("rst_cpu_wait", 64'(cpu_wait), 64'd0);
    chk("rst_busy", 64'(dev_busy), 64'd0);
    chk("rst_done_err", 64'({dev_done, dev_err}), 64'd0);
    chk("rst_sd_lba", sd_lba, 64'd0);

    // Single read on device 1, long transfer
    sb_push(1, 1'b0, 32'h1234, 1'b0);
    d1 = done_cnt[1];
    pulse_req(2'b10, 2'b00, 32'h0, 32'h1234);
    chk("t1_no_strobe_yet", 64'(sd_rd), 64'd0);
    chk("t1_busy_pending", 64'(dev_busy), 64'b10);
    tick(1);
    chk("t1_strobe", 64'(sd_rd), 64'b10);
    chk("t1_cw_high", 64'(cpu_wait), 64'd1);
    chk("t1_grant", 64'(grant), 64'd1);
    chk("t1_lba", 64'(sd_lba[63:32]), 64'h1234);
    hps_serve(1, 3, 512);
    chk("t1_done_pulse", 64'(dev_done), 64'b10);
    chk("t1_cw_fall", 64'(cpu_wait), 64'd0);
    tick(1);
    chk("t1_strobe_len", 64'(strb_len_last), 64'd3);
    chk("t1_cw_len", 64'(cw_high_last), 64'd515);
    chk("t1_done_cnt", 64'(done_cnt[1] - d1), 64'd1);
    chk("t1_done_gone", 64'(dev_done), 64'd0);

    // Simultaneous reads after reset: device 0 then device 1, one idle cycle between
    do_reset();
    sb_push(0, 1'b0, 32'hA0, 1'b0);
    sb_push(1, 1'b0, 32'hB1, 1'b0);
    pulse_req(2'b11, 2'b00, 32'hA0, 32'hB1);
    hps_serve(0, 2, 6);
    hps_serve(1, 2, 6);
    tick(1);
    chk("t2_cw_gap", 64'(cw_low_last), 64'd1);
    chk("t2_grant_last", 64'(grant), 64'd1);

    // Write and read together on device 0: write first, then read
    sb_push(0, 1'b1, 32'hABCD, 1'b0);
    sb_push(0, 1'b0, 32'hABCD, 1'b0);
    d0 = done_cnt[0];
    pulse_req(2'b01, 2'b01, 32'hABCD, 32'h0);
    hps_serve(0, 1, 4);
    hps_serve(0, 2, 4);
    tick(1);
    chk("t3_two_dones", 64'(done_cnt[0] - d0), 64'd2);
    chk("t3_busy_clear", 64'(dev_busy), 64'd0);

    // Watchdog abort with no ack, then a normal transfer
    sb_push(0, 1'b0, 32'h55, 1'b1);
    e0 = err_cnt[0];
    pulse_req(2'b01, 2'b00, 32'h55, 32'h0);
    for (int i = 0; i < TB_TO + 100 && err_cnt[0] == e0; i++) tick(1);
    chk("t4_err_cnt", 64'(err_cnt[0] - e0), 64'd1);
    chk("t4_strobe_len", 64'(strb_len_last), 64'(TB_TO));
    chk("t4_busy_clear", 64'(dev_busy), 64'd0);
    chk("t4_cw_low", 64'(cpu_wait), 64'd0);
    sb_push(1, 1'b0, 32'h77, 1'b0);
    d1 = done_cnt[1];
    pulse_req(2'b10, 2'b00, 32'h0, 32'h77);
    hps_serve(1, 2, 3);
    tick(1);
    chk("t4_recover_done", 64'(done_cnt[1] - d1), 64'd1);

    // Mount change drops device 1's pending request while device 0 runs
    s1 = strb_cnt[1];
    sb_push(0, 1'b0, 32'h99, 1'b0);
    pulse_req(2'b01, 2'b00, 32'h99, 32'h0);
    tick(1);
    chk("t5_strobe0", 64'(sd_rd), 64'b01);
    pulse_req(2'b10, 2'b00, 32'h99, 32'h42);
    chk("t5_busy_both", 64'(dev_busy), 64'b11);
    img_mounted = 2'b10;
    tick(1);
    img_mounted = 2'b00;
    chk("t5_busy_after_mount", 64'(dev_busy), 64'b01);
    hps_serve(0, 2, 5);
    tick(20);
    chk("t5_dev1_never", 64'(strb_cnt[1] - s1), 64'd0);
    chk("t5_cw_idle", 64'(cpu_wait), 64'd0);
    chk("t5_busy_idle", 64'(dev_busy), 64'd0);

    // Reset during XFER: the late ack fall must not produce a completion
    d1 = done_cnt[1];
    e0 = err_cnt[1];
    pulse_req(2'b10, 2'b00, 32'h0, 32'h66);
    tick(1);
    chk("t6_strobe", 64'(sd_rd), 64'b10);
    sd_ack = 2'b10;
    tick(3);
    chk("t6_in_xfer_strobe", 64'(sd_rd), 64'd0);
    chk("t6_in_xfer_cw", 64'(cpu_wait), 64'd1);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_cw", 64'(cpu_wait), 64'd0);
    chk("t6_rst_busy", 64'(dev_busy), 64'd0);
    chk("t6_rst_grant", 64'(grant), 64'd1);
    chk("t6_rst_lba", sd_lba, 64'd0);
    reset = 1'b0;
    tick(1);
    sd_ack = 2'b00;
    tick(5);
    chk("t6_no_done", 64'(done_cnt[1] - d1), 64'd0);
    chk("t6_no_err", 64'(err_cnt[1] - e0), 64'd0);
    chk("t6_outputs", 64'({sd_rd, sd_wr, cpu_wait, dev_busy}), 64'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
